// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared types and constants for the mmio_datenbus data-side
//                bus fabric (FSM states, address map, status layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RAM_WAIT = 2'd1,
        S_ACK      = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    // Address bit that selects the I/O space instead of RAM
    localparam int          IO_BIT       = 31;
    // First I/O index of the input channels
    localparam logic [7:0]  IN_BASE      = 8'h80;
    // I/O index of the status register
    localparam logic [7:0]  STATUS_IDX   = 8'hFF;
    // Read data returned when the RAM never answers
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Status register layout
    localparam int          STATUS_ERR_BIT = 31;
    localparam int          STATUS_CLR_BIT = 0;

endpackage : mmio_pkg
`default_nettype wire

// File: rtl/mmio_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_sync2
//  Description : Parametrised-width two-flop synchroniser for asynchronous
//                input channels. Output lags the input by two clock edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : mmio_sync2
`default_nettype wire

// File: rtl/mmio_datenbus.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_datenbus
//  Description : Data-side bus fabric between the CPU data port, the data RAM
//                and a bank of memory-mapped output registers / synchronised
//                input channels. Adds a status register, a RAM-timeout
//                watchdog and a sticky bus-error flag. Owns the CPU handshake:
//                exactly one acknowledge pulse per access.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_datenbus
    import mmio_pkg::*;
#(
    parameter int          RAM_ADDR_W = 8,
    parameter int          OUT_CH     = 2,
    parameter int          OUT_W      = 8,
    parameter logic [31:0] OUT_RESET  = 32'h0,
    parameter int          IN_CH      = 1,
    parameter int          IN_W       = 8,
    parameter int          TIMEOUT    = 64
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic [31:0]                          CPUDatenAdresse,
    input  logic [31:0]                          CPUDatenRaus,
    input  logic                                 CPULeseDaten,
    input  logic                                 CPUSchreibeDaten,
    output logic [31:0]                          CPUDatenRein,
    output logic                                 CPUDatenGeladen,
    output logic                                 CPUDatenGespeichert,
    output logic [RAM_ADDR_W-1:0]                RAMAdresse,
    output logic [31:0]                          RAMDatenRein,
    output logic                                 RAMLesenAn,
    output logic                                 RAMSchreibenAn,
    input  logic [31:0]                          RAMDatenRaus,
    input  logic                                 RAMDatenBereit,
    input  logic                                 RAMDatenGeschrieben,
    output logic [OUT_CH*OUT_W-1:0]              AusgabeKanaele,
    input  logic [((IN_CH > 0) ? IN_CH : 1)*IN_W-1:0] EingabeKanaele,
    output logic                                 Fehler
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int IN_N = (IN_CH > 0) ? IN_CH : 1;

    state_t                r_state;
    logic                  r_is_write;
    logic [RAM_ADDR_W-1:0] r_ram_addr;
    logic [31:0]           r_ram_wdata;
    logic                  r_ram_rd;
    logic                  r_ram_wr;
    logic [TW-1:0]         r_timer;
    logic [31:0]           r_rdata;
    logic [31:0]           r_rein;
    logic                  r_ack_rd;
    logic                  r_ack_wr;
    logic                  r_fehler;
    logic [OUT_W-1:0]      r_out [OUT_CH];

    logic [IN_W-1:0]       w_in_sync [IN_N];

    logic                  w_req;
    logic                  w_io;
    logic [7:0]            w_idx;
    logic                  w_hit_out;
    logic                  w_hit_in;
    logic                  w_hit_stat;
    logic                  w_unmapped;
    logic [31:0]           w_io_rdata;
    logic                  w_ram_done;
    logic                  w_timeout;
    logic                  w_err_set;
    logic                  w_err_clr;
    logic                  w_out_we;
    logic                  w_unused;

    // ------------------------------------------------------------------
    // Input channel synchronisers
    // ------------------------------------------------------------------
    generate
        if (IN_CH > 0) begin : g_in
            for (genvar gi = 0; gi < IN_CH; gi++) begin : g_sync
                mmio_sync2 #(.W(IN_W)) u_sync (
                    .clk   (Clock),
                    .rst_n (Reset),
                    .i_d   (EingabeKanaele[gi*IN_W +: IN_W]),
                    .o_q   (w_in_sync[gi])
                );
            end
        end else begin : g_no_in
            assign w_in_sync[0] = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_req      = CPULeseDaten | CPUSchreibeDaten;
    assign w_io       = CPUDatenAdresse[IO_BIT];
    assign w_idx      = CPUDatenAdresse[7:0];
    assign w_hit_out  = ({1'b0, w_idx} < 9'(OUT_CH));
    assign w_hit_in   = (IN_CH > 0) && ({1'b0, w_idx} >= {1'b0, IN_BASE}) &&
                        ({1'b0, w_idx} < ({1'b0, IN_BASE} + 9'(IN_CH)));
    assign w_hit_stat = (w_idx == STATUS_IDX);
    assign w_unmapped = !(w_hit_out || w_hit_in || w_hit_stat);

    // I/O read multiplexer; unmapped indices read as zero
    always_comb begin
        w_io_rdata = '0;
        for (int i = 0; i < OUT_CH; i++) begin
            if (w_idx == 8'(i)) begin
                w_io_rdata[OUT_W-1:0] = r_out[i];
            end
        end
        if (IN_CH > 0) begin
            for (int j = 0; j < IN_N; j++) begin
                if (w_idx == (IN_BASE + 8'(j))) begin
                    w_io_rdata[IN_W-1:0] = w_in_sync[j];
                end
            end
        end
        if (w_hit_stat) begin
            w_io_rdata                 = {24'h0, 8'(OUT_CH)};
            w_io_rdata[STATUS_ERR_BIT] = r_fehler;
        end
    end

    assign w_ram_done = r_is_write ? RAMDatenGeschrieben : RAMDatenBereit;
    assign w_timeout  = (r_state == S_RAM_WAIT) && !w_ram_done &&
                        (r_timer == TW'(TIMEOUT - 1));
    assign w_out_we   = (r_state == S_IDLE) && CPUSchreibeDaten && w_io;

    // Error sources: read+write together, unmapped I/O access, RAM timeout
    assign w_err_set  = ((r_state == S_IDLE) && w_req &&
                         ((CPULeseDaten && CPUSchreibeDaten) || (w_io && w_unmapped))) ||
                        w_timeout;
    assign w_err_clr  = w_out_we && w_hit_stat && CPUDatenRaus[STATUS_CLR_BIT];

    // Transaction FSM with registered strobes, acks and read data
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_is_write  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_rd    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_timer     <= '0;
            r_rdata     <= '0;
            r_rein      <= '0;
            r_ack_rd    <= 1'b0;
            r_ack_wr    <= 1'b0;
        end else begin
            r_ack_rd <= 1'b0;
            r_ack_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // Simultaneous read and write is handled as a write
                        r_is_write <= CPUSchreibeDaten;
                        if (w_io) begin
                            if (!CPUSchreibeDaten) begin
                                r_rdata <= w_io_rdata;
                            end
                            r_state <= S_ACK;
                        end else begin
                            r_ram_addr  <= CPUDatenAdresse[RAM_ADDR_W-1:0];
                            r_ram_wdata <= CPUDatenRaus;
                            r_ram_rd    <= !CPUSchreibeDaten;
                            r_ram_wr    <= CPUSchreibeDaten;
                            r_timer     <= '0;
                            r_state     <= S_RAM_WAIT;
                        end
                    end
                end
                S_RAM_WAIT: begin
                    // Request lines are ignored here; the latched access completes
                    if (w_ram_done) begin
                        if (!r_is_write) begin
                            r_rdata <= RAMDatenRaus;
                        end
                        r_ram_rd <= 1'b0;
                        r_ram_wr <= 1'b0;
                        r_state  <= S_ACK;
                    end else if (w_timeout) begin
                        r_rdata  <= TIMEOUT_DATA;
                        r_ram_rd <= 1'b0;
                        r_ram_wr <= 1'b0;
                        r_state  <= S_ACK;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_ACK: begin
                    if (r_is_write) begin
                        r_ack_wr <= 1'b1;
                    end else begin
                        r_ack_rd <= 1'b1;
                        r_rein   <= r_rdata;
                    end
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    // The CPU drops its request after seeing the ack
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output registers update on the IDLE edge, one cycle before the ack
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < OUT_CH; i++) begin
                r_out[i] <= OUT_RESET[OUT_W-1:0];
            end
        end else begin
            for (int i = 0; i < OUT_CH; i++) begin
                if (w_out_we && (w_idx == 8'(i))) begin
                    r_out[i] <= CPUDatenRaus[OUT_W-1:0];
                end
            end
        end
    end

    // Sticky bus error; a set in the same cycle as a clear wins
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_fehler <= 1'b0;
        end else if (w_err_set) begin
            r_fehler <= 1'b1;
        end else if (w_err_clr) begin
            r_fehler <= 1'b0;
        end
    end

    generate
        for (genvar go = 0; go < OUT_CH; go++) begin : g_out
            assign AusgabeKanaele[go*OUT_W +: OUT_W] = r_out[go];
        end
    endgenerate

    assign CPUDatenRein        = r_rein;
    assign CPUDatenGeladen     = r_ack_rd;
    assign CPUDatenGespeichert = r_ack_wr;
    assign RAMAdresse          = r_ram_addr;
    assign RAMDatenRein        = r_ram_wdata;
    assign RAMLesenAn          = r_ram_rd;
    assign RAMSchreibenAn      = r_ram_wr;
    assign Fehler              = r_fehler;

    // Address bits between the RAM window and the I/O select are don't-care
    assign w_unused = ^CPUDatenAdresse;

endmodule : mmio_datenbus
`default_nettype wire

// File: tb/tb_mmio_datenbus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_datenbus
//  Description : Directed self-checking bench for mmio_datenbus with default
//                parameters (OUT_CH=2, OUT_W=8, IN_CH=1, IN_W=8, TIMEOUT=64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_datenbus;

    logic        Clock;
    logic        Reset;
    logic [31:0] CPUDatenAdresse;
    logic [31:0] CPUDatenRaus;
    logic        CPULeseDaten;
    logic        CPUSchreibeDaten;
    logic [31:0] CPUDatenRein;
    logic        CPUDatenGeladen;
    logic        CPUDatenGespeichert;
    logic [7:0]  RAMAdresse;
    logic [31:0] RAMDatenRein;
    logic        RAMLesenAn;
    logic        RAMSchreibenAn;
    logic [31:0] RAMDatenRaus;
    logic        RAMDatenBereit;
    logic        RAMDatenGeschrieben;
    logic [15:0] AusgabeKanaele;
    logic [7:0]  EingabeKanaele;
    logic        Fehler;

    int total = 0;
    int bad   = 0;

    mmio_datenbus u_dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .CPUDatenAdresse     (CPUDatenAdresse),
        .CPUDatenRaus        (CPUDatenRaus),
        .CPULeseDaten        (CPULeseDaten),
        .CPUSchreibeDaten    (CPUSchreibeDaten),
        .CPUDatenRein        (CPUDatenRein),
        .CPUDatenGeladen     (CPUDatenGeladen),
        .CPUDatenGespeichert (CPUDatenGespeichert),
        .RAMAdresse          (RAMAdresse),
        .RAMDatenRein        (RAMDatenRein),
        .RAMLesenAn          (RAMLesenAn),
        .RAMSchreibenAn      (RAMSchreibenAn),
        .RAMDatenRaus        (RAMDatenRaus),
        .RAMDatenBereit      (RAMDatenBereit),
        .RAMDatenGeschrieben (RAMDatenGeschrieben),
        .AusgabeKanaele      (AusgabeKanaele),
        .EingabeKanaele      (EingabeKanaele),
        .Fehler              (Fehler)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        CPULeseDaten     = rd;
        CPUSchreibeDaten = wr;
        CPUDatenAdresse  = a;
        CPUDatenRaus     = d;
    endtask

    // Waits for the ack (bounded), drops the request, checks the ack was single
    task automatic wait_ack(output int n, output logic is_rd, output logic [31:0] d);
        logic got;
        got = 1'b0; n = 0; is_rd = 1'b0; d = '0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (CPUDatenGeladen || CPUDatenGespeichert) begin
                got   = 1'b1;
                is_rd = CPUDatenGeladen;
                d     = CPUDatenRein;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $error("FAIL ack_timeout observed=no_ack expected=ack");
        end
        CPULeseDaten     = 1'b0;
        CPUSchreibeDaten = 1'b0;
        tick();
        chk("ack_single", {62'b0, CPUDatenGeladen, CPUDatenGespeichert}, 64'h0);
        tick();
    endtask

    int          n;
    logic        is_rd;
    logic [31:0] d;
    int          strobe_cycles;

    initial begin
        Reset = 1'b0;
        req(1'b0, 1'b0, 32'h0, 32'h0);
        RAMDatenRaus        = 32'h0;
        RAMDatenBereit      = 1'b0;
        RAMDatenGeschrieben = 1'b0;
        EingabeKanaele      = 8'h11;
        tick(); tick();

        // Reset state
        chk("rst_out",    64'(AusgabeKanaele), 64'h0);
        chk("rst_acks",   {62'b0, CPUDatenGeladen, CPUDatenGespeichert}, 64'h0);
        chk("rst_strobe", {62'b0, RAMLesenAn, RAMSchreibenAn}, 64'h0);
        chk("rst_err",    64'(Fehler), 64'h0);
        chk("rst_rein",   64'(CPUDatenRein), 64'h0);
        Reset = 1'b1;
        tick();

        // I/O write channel 1: register moves at the IDLE edge, ack one cycle later
        req(1'b0, 1'b1, 32'h8000_0001, 32'h0000_00A5);
        tick();
        chk("wr1_out_early", 64'(AusgabeKanaele), 64'hA500);
        chk("wr1_no_ack_yet", 64'(CPUDatenGespeichert), 64'h0);
        tick();
        chk("wr1_ack", {62'b0, CPUDatenGeladen, CPUDatenGespeichert}, 64'h1);
        req(1'b0, 1'b0, 32'h8000_0001, 32'h0);
        tick();
        chk("wr1_ack_single", 64'(CPUDatenGespeichert), 64'h0);
        tick();

        // Read back channel 1
        req(1'b1, 1'b0, 32'h8000_0001, 32'h0);
        wait_ack(n, is_rd, d);
        chk("rd1_lat",  64'(n), 64'd2);
        chk("rd1_type", 64'(is_rd), 64'h1);
        chk("rd1_data", 64'(d), 64'h0000_00A5);

        // Channel 0 write keeps only the low OUT_W bits
        req(1'b0, 1'b1, 32'h8000_0000, 32'h1234_5677);
        wait_ack(n, is_rd, d);
        chk("wr0_out", 64'(AusgabeKanaele), 64'hA577);
        chk("rein_held", 64'(CPUDatenRein), 64'h0000_00A5);

        // Input sync: value changed together with the request is not yet seen
        EingabeKanaele = 8'h3C;
        req(1'b1, 1'b0, 32'h8000_0080, 32'h0);
        wait_ack(n, is_rd, d);
        chk("in_stale", 64'(d), 64'h11);
        req(1'b1, 1'b0, 32'h8000_0080, 32'h0);
        wait_ack(n, is_rd, d);
        chk("in_new", 64'(d), 64'h3C);
        // Only one edge after the change: still the old synchronised value
        EingabeKanaele = 8'h5A;
        tick();
        req(1'b1, 1'b0, 32'h8000_0080, 32'h0);
        wait_ack(n, is_rd, d);
        chk("in_1cyc", 64'(d), 64'h3C);
        // Writes to an input channel are acked and ignored
        req(1'b0, 1'b1, 32'h8000_0080, 32'hFFFF_FFFF);
        wait_ack(n, is_rd, d);
        chk("in_wr_ack", 64'(is_rd), 64'h0);
        chk("in_wr_out", 64'(AusgabeKanaele), 64'hA577);
        chk("in_wr_err", 64'(Fehler), 64'h0);

        // Status register, no error
        req(1'b1, 1'b0, 32'h8000_00FF, 32'h0);
        wait_ack(n, is_rd, d);
        chk("stat0", 64'(d), 64'h0000_0002);

        // Unmapped write: acked, dropped, error set
        req(1'b0, 1'b1, 32'h8000_0040, 32'h0000_00FF);
        tick();
        chk("unm_err", 64'(Fehler), 64'h1);
        wait_ack(n, is_rd, d);
        chk("unm_lat", 64'(n), 64'd1);
        chk("unm_out", 64'(AusgabeKanaele), 64'hA577);
        // Unmapped read returns zero
        req(1'b1, 1'b0, 32'h8000_0010, 32'h0);
        wait_ack(n, is_rd, d);
        chk("unm_rd", 64'(d), 64'h0);
        req(1'b1, 1'b0, 32'h8000_00FF, 32'h0);
        wait_ack(n, is_rd, d);
        chk("stat1", 64'(d), 64'h8000_0002);
        // Status write with bit0 = 0 leaves the flag alone
        req(1'b0, 1'b1, 32'h8000_00FF, 32'h0000_0000);
        wait_ack(n, is_rd, d);
        chk("clr_noop", 64'(Fehler), 64'h1);
        req(1'b0, 1'b1, 32'h8000_00FF, 32'h0000_0001);
        wait_ack(n, is_rd, d);
        chk("clr", 64'(Fehler), 64'h0);

        // Read and write together: a write, plus an error
        req(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0042);
        wait_ack(n, is_rd, d);
        chk("both_type", 64'(is_rd), 64'h0);
        chk("both_out",  64'(AusgabeKanaele), 64'hA542);
        chk("both_err",  64'(Fehler), 64'h1);
        // Both high on the status clear: the set wins
        req(1'b1, 1'b1, 32'h8000_00FF, 32'h0000_0001);
        wait_ack(n, is_rd, d);
        chk("set_wins", 64'(Fehler), 64'h1);
        req(1'b0, 1'b1, 32'h8000_00FF, 32'h0000_0001);
        wait_ack(n, is_rd, d);
        chk("clr2", 64'(Fehler), 64'h0);

        // RAM read answering after three strobe cycles; address changes mid-wait
        req(1'b1, 1'b0, 32'h0000_0105, 32'h0);
        tick();
        chk("ram_addr", 64'(RAMAdresse), 64'h05);
        strobe_cycles = 1;
        CPUDatenAdresse = 32'h8000_0001;
        tick();
        if (RAMLesenAn) strobe_cycles++;
        tick();
        if (RAMLesenAn) strobe_cycles++;
        chk("ram_addr_held", 64'(RAMAdresse), 64'h05);
        RAMDatenRaus   = 32'h1234_5678;
        RAMDatenBereit = 1'b1;
        tick();
        RAMDatenBereit = 1'b0;
        RAMDatenRaus   = 32'h0;
        chk("ram_strobe_drop", 64'(RAMLesenAn), 64'h0);
        chk("ram_strobe_cyc", 64'(strobe_cycles), 64'd3);
        chk("ram_no_ack_yet", 64'(CPUDatenGeladen), 64'h0);
        wait_ack(n, is_rd, d);
        chk("ram_rd_lat",  64'(n), 64'd1);
        chk("ram_rd_data", 64'(d), 64'h1234_5678);
        chk("ram_out_same", 64'(AusgabeKanaele), 64'hA542);

        // RAM write: the read-done input must not complete it
        req(1'b0, 1'b1, 32'h7FFF_FF10, 32'hCAFE_F00D);
        tick();
        chk("ramw_strobe", {62'b0, RAMLesenAn, RAMSchreibenAn}, 64'h1);
        chk("ramw_addr",  64'(RAMAdresse), 64'h10);
        chk("ramw_data",  64'(RAMDatenRein), 64'hCAFE_F00D);
        RAMDatenBereit = 1'b1;
        tick();
        RAMDatenBereit = 1'b0;
        chk("ramw_wrong_done", 64'(RAMSchreibenAn), 64'h1);
        RAMDatenGeschrieben = 1'b1;
        tick();
        RAMDatenGeschrieben = 1'b0;
        wait_ack(n, is_rd, d);
        chk("ramw_ack", {63'b0, is_rd}, 64'h0);
        chk("ramw_lat", 64'(n), 64'd1);

        // RAM never answers: timeout after TIMEOUT+1 cycles
        req(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        wait_ack(n, is_rd, d);
        chk("to_lat",  64'(n), 64'd66);
        chk("to_data", 64'(d), 64'hDEAD_BEEF);
        chk("to_err",  64'(Fehler), 64'h1);
        req(1'b1, 1'b0, 32'h8000_00FF, 32'h0);
        wait_ack(n, is_rd, d);
        chk("to_stat", 64'(d), 64'h8000_0002);
        req(1'b0, 1'b1, 32'h8000_00FF, 32'h0000_0001);
        wait_ack(n, is_rd, d);
        chk("to_clr", 64'(Fehler), 64'h0);

        // Asynchronous reset in the middle of a RAM wait
        req(1'b1, 1'b0, 32'h0000_0030, 32'h0);
        tick(); tick();
        chk("mid_strobe", 64'(RAMLesenAn), 64'h1);
        Reset = 1'b0;
        #1;
        chk("mid_rst_strobe", {62'b0, RAMLesenAn, RAMSchreibenAn}, 64'h0);
        chk("mid_rst_out", 64'(AusgabeKanaele), 64'h0);
        req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        Reset = 1'b1;
        strobe_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (CPUDatenGeladen || CPUDatenGespeichert || RAMLesenAn) strobe_cycles++;
        end
        chk("post_rst_quiet", 64'(strobe_cycles), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mmio_datenbus
`default_nettype wire

// File: doc/mmio_datenbus.md
Name: mmio_datenbus

Overview:
- Data-side bus fabric between the CPU data port, the data RAM and a parametrised bank of memory-mapped I/O channels.
- Generalises the single hard-wired LED latch into OUT_CH read/write output registers and IN_CH synchronised input channels.
- Adds a status register, a RAM-timeout watchdog and a sticky bus-error flag.
- Owns the complete CPU data handshake: one acknowledge pulse per access.

Parameters:
RAM_ADDR_W, 8, data RAM word-address width
OUT_CH, 2, number of output registers (1..128)
OUT_W, 8, bits per output register (1..32)
OUT_RESET, 0, reset value of every output register
IN_CH, 1, number of input channels (0..127)
IN_W, 8, bits per input channel (1..32)
TIMEOUT, 64, RAM wait cycles before abort (>=2)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-low reset
CPUDatenAdresse  in  32  access address
CPUDatenRaus  in  32  CPU write data
CPULeseDaten  in  1  read request, level, held until ack
CPUSchreibeDaten  in  1  write request, level, held until ack
CPUDatenRein  out  32  read data, valid with CPUDatenGeladen
CPUDatenGeladen  out  1  one-cycle read ack
CPUDatenGespeichert  out  1  one-cycle write ack
RAMAdresse  out  RAM_ADDR_W  data RAM word address
RAMDatenRein  out  32  data RAM write data
RAMLesenAn  out  1  RAM read strobe
RAMSchreibenAn  out  1  RAM write strobe
RAMDatenRaus  in  32  RAM read data
RAMDatenBereit  in  1  RAM read done
RAMDatenGeschrieben  in  1  RAM write done
AusgabeKanaele  out  OUT_CH*OUT_W  output registers, channel 0 in LSBs
EingabeKanaele  in  IN_CH*IN_W  asynchronous input channels
Fehler  out  1  sticky bus error

Behaviour:
- Reset low, asynchronous: state IDLE; all ack outputs, RAM strobes and Fehler = 0; CPUDatenRein = 0; every output register = OUT_RESET[OUT_W-1:0]; input synchronisers = 0.
- Address map:
  - Bit 31 = 0 selects RAM; RAMAdresse = addr[RAM_ADDR_W-1:0]; higher bits ignored.
  - Bit 31 = 1 selects I/O; idx = addr[7:0].
  - idx 0..OUT_CH-1: output register, R/W; read data is zero-extended.
  - idx 0x80..0x80+IN_CH-1: input channel, read-only; writes are acked and ignored.
  - idx 0xFF: status register. Read = {Fehler, 23'b0, OUT_CH[7:0]}. Writing bit0 = 1 clears Fehler.
  - Any other idx: unmapped. Read returns 0, write is dropped, both are acked, Fehler is set.
- Input channels pass through 2-FF synchronisers; reads see values 2 cycles old.
- FSM states: IDLE, RAM_WAIT, ACK, HOLD.
  - IDLE, no request: stay.
  - IDLE, I/O request: perform access this edge → ACK.
  - IDLE, RAM request: latch address and write data, raise strobe → RAM_WAIT; timer = 0.
  - RAM_WAIT: strobe held.
    - On the matching done input: latch RAMDatenRaus → ACK.
    - If timer reaches TIMEOUT-1 first: drop strobe, read data = 32'hDEAD_BEEF, set Fehler → ACK.
  - ACK: exactly one cycle of CPUDatenGeladen or CPUDatenGespeichert, matching the request type → HOLD.
  - HOLD: one cycle with requests ignored, because the CPU drops its request on seeing the ack → IDLE.
- Latency: I/O access acks 2 cycles after the request edge. RAM access acks 1 cycle after the done input.
- Read and write both high in IDLE: treated as a write; Fehler set.
- Request change mid-RAM_WAIT: ignored; the latched transaction completes.
- An output register updates on the IDLE edge, so AusgabeKanaele changes one cycle before the ack.
- Fehler set and a status-clear write in the same cycle: set wins.
- CPUDatenRein holds its last value outside ack cycles.

Decomposition:
- Package mmio_pkg: state enum, IO_BIT=31, IN_BASE=8'h80, STATUS_IDX=8'hFF, TIMEOUT_DATA=32'hDEADBEEF, status field positions.
- One sub-module: mmio_sync2, a parametrised-width 2-FF synchroniser, instantiated per input channel.

Test Plan:
- Reset low mid-RAM_WAIT → strobes drop immediately, AusgabeKanaele = OUT_RESET, no ack after release.
- Write 0x000000A5 to 0x80000001 (OUT_W=8) → channel 1 = 0xA5 next edge, CPUDatenGespeichert pulses once, 2 cycles after request; read back returns 0x000000A5.
- RAM read at 0x00000105 with RAM returning 0x12345678 after 3 cycles → RAMAdresse = 0x05, RAMLesenAn high 3 cycles, CPUDatenGeladen with 0x12345678 one cycle after RAMDatenBereit.
- RAM never responds → ack after TIMEOUT+1 cycles with 0xDEADBEEF, Fehler = 1; status read returns bit31 = 1; writing 1 to 0x800000FF clears Fehler.
- EingabeKanaele channel 0 changed to 0x3C → read of 0x80000080 returns 0x3C only once 2 cycles have elapsed.
- Write to unmapped 0x80000040 → ack pulse, no output change, Fehler = 1; read and write both high → treated as write, Fehler = 1.
